// File: rtl/regfile_2r1w_if.sv
// Operand-read / write-back bus of the integer register file.
// The master is the pipeline (decode + write-back); the slave is the register file.
interface regfile_2r1w_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
);
  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata2_o;

  modport master (
    output we_i, waddr_i, wdata_i,
    output re1_i, raddr1_i, re2_i, raddr2_i,
    input  rdata1_o, rdata2_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i,
    input  re1_i, raddr1_i, re2_i, raddr2_i,
    output rdata1_o, rdata2_o
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Integer register file: two combinational read ports, one clocked write port.
// x0 reads as zero and ignores writes. Same-cycle write data and the optional
// write-back holding register are both bypassed to the read ports, so the
// WB_REG setting is not observable at the ports.
module regfile_2r1w #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned WB_REG = 0
) (
  input logic             clk,
  input logic             rst_n,
  regfile_2r1w_if.slave   rf
);

  localparam int unsigned NREGS  = 1 << ADDR_W;
  localparam bit          USE_WB = (WB_REG != 0);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_a_q, pend_a_d;
  logic [DATA_W-1:0] pend_d_q, pend_d_d;

  logic              wr_acc;
  logic              commit_v;
  logic [ADDR_W-1:0] commit_a;
  logic [DATA_W-1:0] commit_d;

  logic              re_p [2];
  logic [ADDR_W-1:0] ra_p [2];
  logic [DATA_W-1:0] rd_p [2];

  assign wr_acc = rf.we_i && (rf.waddr_i != '0);

  // Pending register loads every accepted write (only when buffering is enabled).
  always_comb begin
    pend_v_d = USE_WB && wr_acc;
    pend_a_d = rf.waddr_i;
    pend_d_d = rf.wdata_i;
  end

  // Select what reaches the array this edge: the live write or the buffered one.
  always_comb begin
    if (USE_WB) begin
      commit_v = pend_v_q;
      commit_a = pend_a_q;
      commit_d = pend_d_q;
    end else begin
      commit_v = wr_acc;
      commit_a = rf.waddr_i;
      commit_d = rf.wdata_i;
    end
  end

  // Next array contents: at most one entry updated per cycle.
  always_comb begin
    mem_d = mem_q;
    if (commit_v) begin
      mem_d[commit_a] = commit_d;
    end
  end

  // Array and pending-register state; reset drops any buffered write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
      pend_v_q <= 1'b0;
      pend_a_q <= '0;
      pend_d_q <= '0;
    end else begin
      mem_q    <= mem_d;
      pend_v_q <= pend_v_d;
      pend_a_q <= pend_a_d;
      pend_d_q <= pend_d_d;
    end
  end

  assign re_p[0] = rf.re1_i;
  assign ra_p[0] = rf.raddr1_i;
  assign re_p[1] = rf.re2_i;
  assign ra_p[1] = rf.raddr2_i;

  // Read mux per port; priority: disabled/x0, live write, pending write, array.
  // The live write outranks the pending one, so the later of two writes to the
  // same register is always the one returned.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_p[p] = '0;
      if (!rst_n || !re_p[p] || (ra_p[p] == '0)) begin
        rd_p[p] = '0;
      end else if (wr_acc && (rf.waddr_i == ra_p[p])) begin
        rd_p[p] = rf.wdata_i;
      end else if (pend_v_q && (pend_a_q == ra_p[p])) begin
        rd_p[p] = pend_d_q;
      end else begin
        rd_p[p] = mem_q[ra_p[p]];
      end
    end
  end

  assign rf.rdata1_o = rd_p[0];
  assign rf.rdata2_o = rd_p[1];

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: drives identical stimulus into a WB_REG=0
// and a WB_REG=1 instance and checks both against hand-computed values.
module tb_regfile_2r1w;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;

  logic clk;
  logic rst_n;

  int unsigned n_checks;
  int unsigned n_fail;

  regfile_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
  regfile_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();

  regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW), .WB_REG(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (if_a.slave)
  );

  regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW), .WB_REG(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Checks both ports of both instances against the same expectations.
  task automatic check_all(input string tag, input logic [DW-1:0] exp1, input logic [DW-1:0] exp2);
    check({tag, " wb0 p1"}, if_a.rdata1_o, exp1);
    check({tag, " wb0 p2"}, if_a.rdata2_o, exp2);
    check({tag, " wb1 p1"}, if_b.rdata1_o, exp1);
    check({tag, " wb1 p2"}, if_b.rdata2_o, exp2);
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re1, input logic [AW-1:0] ra1,
                       input logic re2, input logic [AW-1:0] ra2);
    if_a.we_i = we;  if_a.waddr_i = wa;   if_a.wdata_i = wd;
    if_a.re1_i = re1; if_a.raddr1_i = ra1; if_a.re2_i = re2; if_a.raddr2_i = ra2;
    if_b.we_i = we;  if_b.waddr_i = wa;   if_b.wdata_i = wd;
    if_b.re1_i = re1; if_b.raddr1_i = ra1; if_b.re2_i = re2; if_b.raddr2_i = ra2;
    #1;
  endtask

  // Advance past the next rising edge; inputs are changed and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 5'd5, 1'b1, 5'd31);
    check_all("in reset", '0, '0);

    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset values across the whole address space.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(31 - i));
      check_all($sformatf("reset x%0d", i), '0, '0);
    end

    // Write x5, read it the following cycle; port 2 disabled on the same address.
    drive(1'b1, 5'd5, 64'h1234_5678_9ABC_DEF0, 1'b0, '0, 1'b0, '0);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd5, 1'b0, 5'd5);
    check_all("wr x5 n+1", 64'h1234_5678_9ABC_DEF0, '0);
    step();
    check_all("wr x5 n+2", 64'h1234_5678_9ABC_DEF0, '0);

    // Same-cycle bypass over an older value in x7.
    drive(1'b1, 5'd7, 64'h11, 1'b0, '0, 1'b0, '0);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 5'd7);
    check_all("x7 old", 64'h11, 64'h11);
    drive(1'b1, 5'd7, 64'hAA, 1'b1, 5'd7, 1'b1, 5'd7);
    check_all("bypass x7", 64'hAA, 64'hAA);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 5'd7);
    check_all("x7 n+1", 64'hAA, 64'hAA);
    step();
    check_all("x7 n+2", 64'hAA, 64'hAA);

    // Read enable beats bypass.
    drive(1'b1, 5'd10, 64'hBEEF, 1'b0, 5'd10, 1'b1, 5'd10);
    check_all("re0 bypass", '0, 64'hBEEF);
    step();

    // x0 immunity.
    drive(1'b1, 5'd0, '1, 1'b1, 5'd0, 1'b1, 5'd0);
    check_all("x0 same", '0, '0);
    step();
    check(" x0 pend_v", {63'd0, dut_b.pend_v_q}, '0);
    drive(1'b0, '0, '0, 1'b1, 5'd0, 1'b1, 5'd10);
    check_all("x0 next", '0, 64'hBEEF);
    step();

    // Overlapping writes to x3 (pending entry superseded by a newer live write).
    drive(1'b1, 5'd3, 64'd1, 1'b1, 5'd3, 1'b1, 5'd3);
    check_all("x3 N", 64'd1, 64'd1);
    step();
    drive(1'b1, 5'd3, 64'd2, 1'b1, 5'd3, 1'b1, 5'd3);
    check_all("x3 N+1", 64'd2, 64'd2);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd3, 1'b1, 5'd3);
    check_all("x3 N+2", 64'd2, 64'd2);
    step();
    check_all("x3 N+3", 64'd2, 64'd2);

    // Back-to-back writes to different registers, read both ports afterwards.
    drive(1'b1, 5'd20, 64'hA0, 1'b1, 5'd20, 1'b1, 5'd3);
    check_all("b2b x20", 64'hA0, 64'd2);
    step();
    drive(1'b1, 5'd31, 64'hF0F0_0000_0000_0F0F, 1'b1, 5'd20, 1'b1, 5'd31);
    check_all("b2b x31", 64'hA0, 64'hF0F0_0000_0000_0F0F);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd31, 1'b1, 5'd20);
    check_all("b2b after", 64'hF0F0_0000_0000_0F0F, 64'hA0);
    step();

    // Reset while x9 sits in the pending register.
    drive(1'b1, 5'd9, 64'h55, 1'b1, 5'd9, 1'b0, '0);
    check_all("x9 bypass", 64'h55, '0);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd9, 1'b1, 5'd5);
    check_all("x9 pend", 64'h55, 64'h1234_5678_9ABC_DEF0);
    rst_n = 1'b0;
    #1;
    check_all("x9 in reset", '0, '0);
    check(" rst pend_v", {63'd0, dut_b.pend_v_q}, '0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("x9 after rst", '0, '0);
    step();
    check_all("x9 after edge", '0, '0);
    drive(1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 5'd31);
    check_all("others cleared", '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
